// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration helpers for the uart_rx_capture receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_t;

    // Integer clocks per bit; the top rejects results below 4 at elaboration.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; full/empty come from the occupancy count.
module uart_rx_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push_i & (~full_o | do_pop);
    assign level_o = level_q;
    // hold_q keeps the last popped byte visible once the FIFO drains.
    assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and a byte FIFO on a valid/ready stream.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter  int unsigned CLK_FREQ_HZ = 25000000,
    parameter  int unsigned BAUD_RATE   = 781250,
    parameter  int unsigned DIV         = calc_div(CLK_FREQ_HZ, BAUD_RATE),
    parameter  int unsigned FIFO_DEPTH  = 16,
    localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    input  logic          rx_en_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          frame_err_o,
    output logic          overflow_o,
    output logic [LW-1:0] level_o
);

    localparam int unsigned    DW        = $clog2(DIV);
    localparam logic [DW-1:0]  HALF_LOAD = DW'(DIV / 2 - 1);
    localparam logic [DW-1:0]  BIT_LOAD  = DW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_capture: DIV must be at least 4");
    end

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, frame_err;
    logic          fifo_full, fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        if (!rx_en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s_q) begin
                        div_d   = HALF_LOAD;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (div_q != '0) begin
                        div_d = div_q - DW'(1);
                    end else if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        div_d   = BIT_LOAD;
                        bit_d   = '0;
                        state_d = StData;
                    end
                end
                StData: begin
                    if (div_q != '0) begin
                        div_d = div_q - DW'(1);
                    end else begin
                        shift_d[bit_q] = rx_s_q;
                        div_d          = BIT_LOAD;
                        if (bit_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (div_q != '0) begin
                        div_d = div_q - DW'(1);
                    end else if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = StWaitHigh;
                    end
                end
                StWaitHigh: begin
                    // A held-low line must return high before a new start is accepted.
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (shift_q),
        .pop_i  (ready_i),
        .data_o (data_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(level_o)
    );

    assign valid_o     = ~fifo_empty;
    assign frame_err_o = frame_err;
    assign overflow_o  = push & fifo_full & ~ready_i;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Self-checking bench for uart_rx_capture: table vectors, corner sequences and random frames.
module tb_uart_rx_capture;

    localparam int DIV   = 32;
    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_i    = 1'b1;
    logic       rx_en_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o;
    logic [4:0] level_o;

    uart_rx_capture #(
        .CLK_FREQ_HZ(25000000),
        .BAUD_RATE  (781250),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rx_en_i    (rx_en_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    bit         rand_rdy = 1'b0;
    logic [7:0] got_q[$];

    // Observe the stream and pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_err_o) fe_cnt++;
            if (overflow_o) ov_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic line(input logic b, input int n);
        rx_i = b;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        line(1'b0, DIV);
        for (int i = 0; i < 8; i++) line(d[i], DIV);
        line(stop, DIV);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         exp_bytes;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] d;
    logic [7:0] exp_q[$];
    int         gb, fb, ob, exp_fe;
    bit         bad;

    initial begin
        vecs[0] = '{8'h65, 1'b1, 0,   1, 0};
        vecs[1] = '{8'hA5, 1'b0, 100, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, 0,   1, 0};
        vecs[3] = '{8'h00, 1'b1, 0,   1, 0};
        vecs[4] = '{8'hFF, 1'b1, 0,   1, 0};
        vecs[5] = '{8'h5A, 1'b0, 0,   0, 1};
        vecs[6] = '{8'h81, 1'b1, 0,   1, 0};

        // Reset state
        repeat (3) tick();
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_frame_err", frame_err_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_level", level_o, 0);
        rst = 1'b0;
        line(1'b1, 10);

        // Glitch shorter than half a bit is a false start
        gb = got_q.size(); fb = fe_cnt;
        line(1'b0, 10);
        line(1'b1, 60);
        check("glitch_bytes", got_q.size() - gb, 0);
        check("glitch_fe", fe_cnt - fb, 0);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            gb = got_q.size(); fb = fe_cnt;
            send_byte(vecs[v].data, vecs[v].stop);
            line(1'b0, vecs[v].hold);
            line(1'b1, 40);
            check("vec_bytes", got_q.size() - gb, vecs[v].exp_bytes);
            check("vec_fe", fe_cnt - fb, vecs[v].exp_fe);
            if (vecs[v].exp_bytes != 0) check("vec_data", got_q[gb], vecs[v].data);
            check("vec_level", level_o, 0);
        end

        // Overflow: 17 bytes into a 16-entry FIFO with no consumer
        ready_i = 1'b0; gb = got_q.size(); ob = ov_cnt;
        for (int b = 0; b < 17; b++) begin
            send_byte(8'(b), 1'b1);
            line(1'b1, 4);
            if (b == 15) begin
                check("ovf_none_before", ov_cnt - ob, 0);
                check("ovf_full_level", level_o, 16);
            end
        end
        check("ovf_pulse", ov_cnt - ob, 1);
        check("ovf_level", level_o, 16);
        check("ovf_head", data_o, 8'h00);
        ready_i = 1'b1;
        line(1'b1, 24);
        check("ovf_drain_count", got_q.size() - gb, 16);
        for (int b = 0; b < 16; b++) check("ovf_drain_data", got_q[gb + b], b);
        check("ovf_drain_level", level_o, 0);
        check("ovf_hold_last", data_o, 8'h0F);

        // Full FIFO with a pop landing on the stop-sample cycle of 0x77
        ready_i = 1'b0; gb = got_q.size(); ob = ov_cnt;
        for (int b = 0; b < 16; b++) begin
            send_byte(8'h80 + 8'(b), 1'b1);
            line(1'b1, 4);
        end
        check("fullpop_level_before", level_o, 16);
        d = 8'h77;
        line(1'b0, DIV);
        for (int i = 0; i < 8; i++) line(d[i], DIV);
        line(1'b1, 18);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        line(1'b1, 13);
        check("fullpop_no_ovf", ov_cnt - ob, 0);
        check("fullpop_level", level_o, 16);
        ready_i = 1'b1;
        line(1'b1, 24);
        check("fullpop_count", got_q.size() - gb, 17);
        check("fullpop_first", got_q[gb], 8'h80);
        check("fullpop_last", got_q[got_q.size() - 1], 8'h77);

        // Receiver disabled after three data bits
        gb = got_q.size(); fb = fe_cnt;
        d = 8'hC3;
        line(1'b0, DIV);
        for (int i = 0; i < 3; i++) line(d[i], DIV);
        rx_en_i = 1'b0;
        for (int i = 3; i < 8; i++) line(d[i], DIV);
        line(1'b1, DIV + 10);
        rx_en_i = 1'b1;
        line(1'b1, 10);
        check("dis_bytes", got_q.size() - gb, 0);
        check("dis_fe", fe_cnt - fb, 0);
        send_byte(8'hC3, 1'b1);
        line(1'b1, 20);
        check("dis_after_count", got_q.size() - gb, 1);
        check("dis_after_data", got_q[gb], 8'hC3);

        // Reset asserted mid-DATA with a byte already buffered
        ready_i = 1'b0;
        send_byte(8'h99, 1'b1);
        line(1'b1, 20);
        check("rstmid_pre_level", level_o, 1);
        check("rstmid_pre_head", data_o, 8'h99);
        d = 8'h12;
        line(1'b0, DIV);
        for (int i = 0; i < 5; i++) line(d[i], DIV);
        rst = 1'b1;
        #1;
        check("rstmid_level", level_o, 0);
        check("rstmid_valid", valid_o, 0);
        check("rstmid_data", data_o, 0);
        check("rstmid_fe", frame_err_o, 0);
        rx_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        ready_i = 1'b1;
        gb = got_q.size(); fb = fe_cnt;
        line(1'b1, 40);
        check("rstmid_no_bytes", got_q.size() - gb, 0);
        send_byte(8'h5A, 1'b1);
        line(1'b1, 20);
        check("rstmid_after_count", got_q.size() - gb, 1);
        check("rstmid_after_data", got_q[gb], 8'h5A);
        check("rstmid_after_fe", fe_cnt - fb, 0);

        // Random frames, gaps, framing errors and consumer back-pressure
        gb = got_q.size(); fb = fe_cnt; ob = ov_cnt; exp_fe = 0;
        rand_rdy = 1'b1;
        for (int r = 0; r < 30; r++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_byte(d, !bad);
            if (bad) begin
                exp_fe++;
                line(1'b1, 4 + int'($urandom_range(0, 10)));
            end else begin
                exp_q.push_back(d);
                line(1'b1, int'($urandom_range(0, 10)));
            end
        end
        rand_rdy = 1'b0;
        ready_i  = 1'b1;
        line(1'b1, 30);
        check("rnd_count", got_q.size() - gb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check("rnd_data", got_q[gb + i], exp_q[i]);
        check("rnd_fe", fe_cnt - fb, exp_fe);
        check("rnd_ovf", ov_cnt - ob, 0);
        check("rnd_level", level_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver that consumes the SoC `uart_tx` pad stream, the same line the bench UART model listens on.
- Oversamples the line with a fixed integer baud divider, deserialises bytes LSB-first, checks the stop bit, and buffers bytes in a small FIFO.
- Bytes leave on a valid/ready stream for an on-chip logger or stdout-capture path.
- Reports framing errors and FIFO overflow as single-cycle pulses.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency.
- BAUD_RATE, 781250, line rate.
- DIV, CLK_FREQ_HZ/BAUD_RATE (=32), clocks per bit. Must be ≥ 4 and is elaborated as an integer.
- FIFO_DEPTH, 16, byte buffer entries. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_i  in  1  serial line, asynchronous to clk, idles high.
- rx_en_i  in  1  receiver enable. When low, the FSM is held in IDLE.
- data_o  out  8  byte at FIFO head.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accept. A pop occurs when valid_o & ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overflow_o  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, on port `rst`. All flops clear on assertion; rst is released synchronously by the system.
- Reset values:
  - data_o = 0, valid_o = 0, frame_err_o = 0, overflow_o = 0, level_o = 0.
  - Synchroniser flops = 1 (line idle).
  - State = IDLE, bit counter = 0, divider counter = 0.
- Input sync: rx_i passes through a 2-flop synchroniser. The FSM sees rx_s, 2 cycles late.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_en_i & falling edge of rx_s (previous 1, current 0), load divider with DIV/2-1 and go to START.
  - START: at divider==0, sample rx_s (mid start bit).
    - If 1: false start, go to IDLE, no pulse.
    - If 0: load DIV-1, bit counter = 0, go to DATA.
  - DATA: at divider==0, shift rx_s into bit[bit counter] (LSB first) and reload DIV-1.
    - After bit 7 is sampled, go to STOP.
  - STOP: at divider==0, sample rx_s.
    - If 1: push the byte, go to IDLE.
    - If 0: frame_err_o pulses for 1 cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being re-decoded as a start bit.
- rx_en_i deasserted mid-frame: next cycle forces IDLE, the partial byte is discarded, no pulses. FIFO contents are retained.
- Latency: the push happens on the cycle of the stop-bit sample. valid_o and data_o update on the following clock edge.
- FIFO:
  - Synchronous, first-word-fall-through. data_o always shows the head; data_o holds its last value when empty.
  - Push when full with no simultaneous pop: byte dropped, overflow_o pulses for 1 cycle, contents unchanged.
  - Push while full with a simultaneous pop: both occur, level unchanged, no overflow.
  - Push and pop when empty: the byte is accepted. Pop is ignored since valid_o=0 that cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Full/empty is distinguished by level_o.
- Divider arithmetic:
  - Counter is $clog2(DIV) bits and counts down, with no wrap below 0.
  - Sampling point sits DIV/2 cycles after the detected edge, ±1 cycle of synchroniser skew.
- No parity. A frame with rx held low indefinitely yields exactly one frame_err_o pulse.

Decomposition:
- Package uart_rx_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - constant function calc_div(clk_hz, baud), with an elaboration assertion for DIV ≥ 4.
- Sub-module: uart_rx_fifo, a generic byte FWFT FIFO with push/pop/full/empty/level. The top contains the synchroniser, divider, and FSM.

Test Plan:
- Reset then single byte: DIV=32, drive 0x65 as 8N1 at 32 clk/bit, ready_i=1 → one valid_o beat with data_o=0x65, no pulses, level_o returns to 0.
- Glitch rejection: rx_i low for 10 clocks then high → no byte, state back to IDLE, no frame_err_o.
- Framing error: send 0xA5 with the stop bit low, then hold low for 100 clocks → exactly one frame_err_o pulse, level_o=0. The next valid frame 0x3C is received correctly.
- Overflow: ready_i=0, send 17 bytes 0x00..0x10 → level_o=16, one overflow_o pulse on byte 0x10. Then ready_i=1 drains 0x00..0x0F in order.
- Full with simultaneous pop: FIFO full, pulse ready_i on the stop-sample cycle of a new byte 0x77 → no overflow_o, level_o stays 16, 0x77 is last out.
- Disable / reset mid-frame: drop rx_en_i after 3 data bits → no push. Separately, assert rst mid-DATA → all outputs 0 immediately, and a following byte 0x5A is received correctly.
